wavelet_readout_rx: RTL
=======================

WAVELET_READOUT_RX -- requirements
Module: wavelet_readout_rx

Interface
REQ-001 Parameter DECIM_LOG2, default 8, log2 of the decimation window length in clk_master cycles (valid range 2..12).
REQ-002 Parameter ACC_W, default DECIM_LOG2+2, signed width of each output sample.
REQ-003 The block SHALL provide these ports, one per line:
- clk_master  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ud_en  in  1  readout enable, shared with the cores.
- read_out_I  in  2  I feedback pulses; bit0 = fb+, bit1 = fb-.
- read_out_Q  in  2  Q feedback pulses, same encoding.
- clr_ovf  in  1  clears the sticky overflow flag.
- sample_I  out  ACC_W  signed decimated I sample.
- sample_Q  out  ACC_W  signed decimated Q sample.
- out_valid  out  1  sample pair available.
- out_ready  in  1  consumer accepts the sample pair.
- overflow  out  1  sticky flag: a window result was dropped.
- busy  out  1  high while in RUN.

Function
REQ-004 The block SHALL register read_out_I/Q and ud_en once before use, giving 1 cycle of input latency.
REQ-005 Per-cycle increment SHALL be: 01 -> +1, 10 -> -1, 00 -> 0, 11 -> 0, for each channel independently.
REQ-006 FSM states SHALL be IDLE, RUN and DUMP.
- IDLE -> RUN on registered ud_en=1.
- RUN -> DUMP when window count reaches 2^DECIM_LOG2-1 and that sample is accumulated.
- DUMP -> RUN after 1 cycle if ud_en is still 1, else DUMP -> IDLE.
- RUN -> IDLE whenever registered ud_en=0.
REQ-007 In RUN, each cycle SHALL add the increment to the accumulator and increment the window counter; the counter wraps to 0 at the window end.
REQ-008 At window end the final total, including the last sample, SHALL go to a result register, and the accumulator SHALL restart from 0 with no sample lost or counted twice.
REQ-009 In DUMP, if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, the result SHALL load into sample_I/Q and out_valid SHALL be 1 on the next cycle.
REQ-010 In DUMP, if out_valid=1 and out_ready=0, the new result SHALL be discarded, sample_I/Q SHALL be held, and overflow SHALL be set.
REQ-011 out_valid SHALL stay 1 and sample_I/Q SHALL stay stable until a cycle with out_ready=1; out_valid then clears unless a new load happens in that same cycle.
REQ-012 Latency from the last input sample of a window at the ports to out_valid=1 SHALL be 3 cycles.
REQ-013 Accumulation SHALL be signed two's complement with range -2^DECIM_LOG2..+2^DECIM_LOG2 and SHALL never saturate or wrap.
REQ-014 When ud_en falls mid-window, the partial window SHALL be discarded, the accumulator and counter cleared, and any pending output left intact.
REQ-015 overflow SHALL be cleared by clr_ovf=1; if clr_ovf and a new overflow occur in the same cycle, set wins.

Reset
REQ-016 On rst=1 the FSM SHALL go to IDLE, and all accumulators, counters and input registers SHALL clear to 0.
REQ-017 Output values while rst=1 and on the cycle after it SHALL be: sample_I=0, sample_Q=0, out_valid=0, overflow=0, busy=0.
REQ-018 Reset asserted mid-window or mid-handshake SHALL abort the operation and discard any pending sample.

Structure
REQ-019 A shared package wavelet_rx_pkg SHALL hold the FSM state enum, the increment-decode constants and the DECIM_LOG2 default.
REQ-020 One sub-module, readout_accum, SHALL implement decode plus accumulator plus result register for one channel, instantiated twice (I, Q).
REQ-021 The FSM and window counter SHALL be single and shared by both channels.

Verification (DECIM_LOG2=4, 16-cycle window)
REQ-022 ud_en=1, I=01 for 16 cycles, Q=00 -> sample_I=+16, sample_Q=0, out_valid 3 cycles after the last sample.
REQ-023 I alternating 01/10, Q=10 constant, with 11 injected on I -> sample_I=0, sample_Q=-16.
REQ-024 out_ready=0 across two window ends -> first sample is held and overflow=1; clr_ovf -> overflow=0.
REQ-025 out_ready=1 on the exact DUMP cycle of the next window -> new sample loads, out_valid stays 1, overflow=0.
REQ-026 ud_en drops at cycle 7 then returns -> next result covers only the 16 new cycles; the pending output is unchanged.
REQ-027 rst pulsed mid-window with out_valid=1 -> all outputs 0 next cycle, and the first post-reset window is correct.

Source files
------------

// File: rtl/wavelet_rx_pkg.sv
// ============================================================================
// wavelet_rx_pkg : shared FSM state, pulse-decode constants and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package wavelet_rx_pkg;

   localparam int DECIM_LOG2_DEFAULT = 8;

   localparam logic [1:0] PULSE_POS = 2'b01;
   localparam logic [1:0] PULSE_NEG = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DUMP = 2'd2
   } state_t;

   // Both-pulses-at-once (11) cancels to zero, same as no pulse.
   function automatic logic signed [1:0] decode_pulse(input logic [1:0] p);
      logic signed [1:0] inc;
      case (p)
         PULSE_POS: inc = 2'sb01;
         PULSE_NEG: inc = 2'sb11;
         default:   inc = 2'sb00;
      endcase
      return inc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/readout_accum.sv
// ============================================================================
// readout_accum : one-channel pulse decode, window accumulator, result register
// Rev 1.0
// ============================================================================
`default_nettype none

module readout_accum
   import wavelet_rx_pkg::*;
#(
   parameter int ACC_W = 10
) (
   input  logic             clk_master,
   input  logic             rst,
   input  logic             acc_en,
   input  logic             win_end,
   input  logic [1:0]       pulses,
   output logic [ACC_W-1:0] result
);

   logic signed [1:0]       inc;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] res_q, res_d;

   always_comb begin
      inc   = decode_pulse(pulses);
      sum   = acc_q + {{(ACC_W-2){inc[1]}}, inc};
      acc_d = acc_q;
      res_d = res_q;
      if (!acc_en) begin
         acc_d = '0;
      end else if (win_end) begin
         // Final sample lands in the result; the next window starts from zero.
         res_d = sum;
         acc_d = '0;
      end else begin
         acc_d = sum;
      end
   end

   always_ff @(posedge clk_master) begin
      if (rst) begin
         acc_q <= '0;
         res_q <= '0;
      end else begin
         acc_q <= acc_d;
         res_q <= res_d;
      end
   end

   assign result = res_q;

endmodule

`default_nettype wire

// File: rtl/wavelet_readout_rx.sv
// ============================================================================
// wavelet_readout_rx : I/Q feedback-pulse decimator with ready/valid output
// Rev 1.0
// ============================================================================
`default_nettype none

module wavelet_readout_rx
   import wavelet_rx_pkg::*;
#(
   parameter int DECIM_LOG2 = DECIM_LOG2_DEFAULT,
   parameter int ACC_W      = DECIM_LOG2 + 2
) (
   input  logic             clk_master,
   input  logic             rst,
   input  logic             ud_en,
   input  logic [1:0]       read_out_I,
   input  logic [1:0]       read_out_Q,
   input  logic             clr_ovf,
   output logic [ACC_W-1:0] sample_I,
   output logic [ACC_W-1:0] sample_Q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             busy
);

   localparam logic [DECIM_LOG2-1:0] CNT_LAST = {DECIM_LOG2{1'b1}};
   localparam logic [DECIM_LOG2-1:0] CNT_ONE  = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic                  en_q, en_d;
   logic [1:0]            pi_q, pi_d;
   logic [1:0]            pq_q, pq_d;
   logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0]      out_i_q, out_i_d;
   logic [ACC_W-1:0]      out_q_q, out_q_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic [ACC_W-1:0]      result_i, result_q;
   logic                  win_end;
   logic                  load;
   logic                  drop;

   assign win_end = en_q && (cnt_q == CNT_LAST);

   always_comb begin
      en_d    = ud_en;
      pi_d    = read_out_I;
      pq_d    = read_out_Q;
      cnt_d   = en_q ? cnt_q + CNT_ONE : '0;
      state_d = state_q;

      case (state_q)
         ST_IDLE: if (en_q) state_d = ST_RUN;
         ST_RUN: begin
            if (!en_q)        state_d = ST_IDLE;
            else if (win_end) state_d = ST_DUMP;
         end
         ST_DUMP: state_d = en_q ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A held sample is never overwritten; a result arriving behind it is dropped.
      load    = (state_q == ST_DUMP) && (!valid_q || out_ready);
      drop    = (state_q == ST_DUMP) && valid_q && !out_ready;
      out_i_d = load ? result_i : out_i_q;
      out_q_d = load ? result_q : out_q_q;

      valid_d = valid_q;
      if (load)           valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;

      ovf_d = drop | (ovf_q & ~clr_ovf);
   end

   always_ff @(posedge clk_master) begin
      if (rst) begin
         state_q <= ST_IDLE;
         en_q    <= 1'b0;
         pi_q    <= '0;
         pq_q    <= '0;
         cnt_q   <= '0;
         out_i_q <= '0;
         out_q_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         pi_q    <= pi_d;
         pq_q    <= pq_d;
         cnt_q   <= cnt_d;
         out_i_q <= out_i_d;
         out_q_q <= out_q_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   readout_accum #(.ACC_W(ACC_W)) u_acc_i (
      .clk_master (clk_master),
      .rst        (rst),
      .acc_en     (en_q),
      .win_end    (win_end),
      .pulses     (pi_q),
      .result     (result_i)
   );

   readout_accum #(.ACC_W(ACC_W)) u_acc_q (
      .clk_master (clk_master),
      .rst        (rst),
      .acc_en     (en_q),
      .win_end    (win_end),
      .pulses     (pq_q),
      .result     (result_q)
   );

   assign sample_I  = out_i_q;
   assign sample_Q  = out_q_q;
   assign out_valid = valid_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q == ST_RUN);

endmodule

`default_nettype wire
